pipe_buf_stage: RTL and testbench
=================================

# pipe_buf_stage

Parametrised pipeline buffer register for the RISC-V pipeline, generalising the fixed IF/ID, ID/EX, EX/MEM and MEM/WB buffers into one reusable stage. It carries an arbitrary-width packed payload, such as any stage struct flattened to a vector, under a valid/ready handshake. It adds stall back-pressure, synchronous flush (bubble insertion) and an optional two-entry skid mode that registers `in_ready`. One instance sits between each pair of adjacent pipeline stages.

## Interface
- `WIDTH`, 32: payload width in bits; must be ≥1.
- `SKID`, 1: 0 = single-entry register, where `in_ready` is combinational from `out_ready`. 1 = two-entry skid buffer, where `in_ready` is registered.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `flush` in 1: synchronous; empties the stage and turns its contents into a bubble.
- `in_valid` in 1: upstream payload valid.
- `in_ready` out 1: stage can accept a payload this cycle.
- `in_data` in WIDTH: upstream payload.
- `out_valid` out 1: `out_data` holds a live payload.
- `out_ready` in 1: downstream accepts; low = stall.
- `out_data` out WIDTH: head payload; all-zero when `out_valid`=0.
- `occupancy` out 2: number of held entries (0..2; max 1 when `SKID`=0).

## Operation
- Transfers:
  - In-fire = `in_valid` & `in_ready`.
  - Out-fire = `out_valid` & `out_ready`.
  - Payloads leave in arrival order; none are dropped or duplicated except by `flush`.
- Storage:
  - Main register `main` drives `out_data`.
  - Skid register `skid` exists only when `SKID`=1.
  - Each entry has a valid bit.
- `SKID`=1 state machine (state = `occupancy`):
  - EMPTY: in-fire → ONE, `main`←`in_data`.
  - ONE, in-fire and out-fire → ONE, `main`←`in_data`.
  - ONE, in-fire only → TWO, `skid`←`in_data`.
  - ONE, out-fire only → EMPTY, `main`←0.
  - ONE, neither → hold.
  - TWO: `in_ready`=0. Out-fire → ONE, `main`←`skid`, `skid`←0. Otherwise hold.
  - `in_ready` = (state ≠ TWO), decoded from registered state only; no combinational path from `out_ready`.
- `SKID`=0:
  - `in_ready` = ~`out_valid` | `out_ready`.
  - In-fire → `main`←`in_data`, valid←1.
  - Out-fire without in-fire → `main`←0, valid←0.
  - Otherwise hold.
- `flush`:
  - Highest synchronous priority.
  - At the edge with `flush`=1: all valids←0, `main`←0, `skid`←0, state←EMPTY.
  - A concurrent in-fire payload is discarded.
  - A concurrent out-fire still counts as consumed downstream this cycle.
- Bubble: an empty stage presents `out_data`=0, which decodes as all control bits deasserted, i.e. a NOP.
- `in_data` is sampled only on in-fire. A change on `in_data` while stalled has no effect on stored entries.

## Timing
- Reset (asynchronous, immediate):
  - `out_valid`=0, `out_data`=0, `occupancy`=0.
  - `in_ready`=1, since state is EMPTY; inputs are ignored while `reset`=1.
- Latency: a payload accepted at edge N appears on `out_data` with `out_valid`=1 after edge N. Minimum latency is 1 cycle.
- Throughput: 1 payload/cycle sustained when `out_ready`=1 in both modes.
- `SKID`=1 back-pressure:
  - `out_ready` falling takes effect on `in_ready` one edge later.
  - The in-flight payload lands in `skid`; no loss.
- `SKID`=0: `in_ready` follows `out_ready` in the same cycle (combinational).
- Reset asserted mid-transfer aborts all entries. The first accept after deassertion occurs at the first edge with `reset`=0.
- `flush` and `out_ready`=0 together: the stage empties; the stalled payload is lost by design.

## Test plan
- Streaming, `SKID`=1, `WIDTH`=32:
  - Stimulus: `in_valid`=1 with data 0x1,0x2,0x3 on consecutive cycles; `out_ready`=1.
  - Response: `out_data` shows 0x1,0x2,0x3 one cycle later; `occupancy` stays 1.
- Stall fill, `SKID`=1:
  - Stimulus: send 0xA, 0xB, 0xC with `out_ready`=0.
  - Response: `occupancy` 1→2; `in_ready`=0 after the second accept; 0xC is held upstream.
  - Then raise `out_ready`: outputs 0xA,0xB,0xC in order with no gaps.
- Flush:
  - Stimulus: `occupancy`=2 (0xA,0xB), then `flush`=1 with `in_valid`=1, data 0xD.
  - Response: next cycle `out_valid`=0, `out_data`=0, `occupancy`=0, `in_ready`=1; 0xD never appears.
- `SKID`=0 stall:
  - Stimulus: hold 0x55 with `out_ready`=0.
  - Response: `in_ready`=0 in the same cycle; `out_data` stays 0x55.
  - Then `out_ready`=1 and `in_valid`=1 (0x66): 0x55 consumed, 0x66 shown next cycle.
- Async reset:
  - Stimulus: assert `reset` mid-cycle with `occupancy`=2.
  - Response: `out_valid`, `out_data`, `occupancy` go to 0 immediately, without waiting for an edge.
- Width:
  - Stimulus: `WIDTH`=1 and `WIDTH`=300, with alternating all-ones/all-zeros payloads.
  - Response: bit-exact pass-through.

Source files
------------

// File: rtl/pipe_buf_stage.sv
// Pipeline buffer stage: valid/ready register between two adjacent pipeline stages.
// SKID=1 gives a two-entry skid buffer with a registered in_ready; SKID=0 gives a
// single-entry register whose in_ready passes out_ready through combinationally.
// An empty stage always presents an all-zero payload so it decodes as a bubble (NOP).
module pipe_buf_stage #(
    parameter int unsigned WIDTH = 32,
    parameter bit          SKID  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    generate
        if (SKID) begin : g_skid
            // State encoding equals the number of held entries.
            typedef enum logic [1:0] {
                StEmpty = 2'd0,
                StOne   = 2'd1,
                StTwo   = 2'd2
            } state_e;

            state_e           state_q, state_d;
            logic [WIDTH-1:0] main_q, main_d;
            logic [WIDTH-1:0] skid_q, skid_d;
            logic             in_fire, out_fire;

            // in_ready depends on registered state only, breaking the out_ready path.
            assign in_ready  = (state_q != StTwo);
            assign out_valid = (state_q != StEmpty);
            assign out_data  = main_q;
            assign occupancy = state_q;
            assign in_fire   = in_valid & in_ready;
            assign out_fire  = out_valid & out_ready;

            // State and entry registers.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q <= StEmpty;
                    main_q  <= '0;
                    skid_q  <= '0;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                end
            end

            // Next state; flush wins over any transfer and drops the incoming payload.
            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (flush) begin
                    state_d = StEmpty;
                    main_d  = '0;
                    skid_d  = '0;
                end else begin
                    unique case (state_q)
                        StEmpty: begin
                            if (in_fire) begin
                                state_d = StOne;
                                main_d  = in_data;
                            end
                        end
                        StOne: begin
                            if (in_fire && out_fire) begin
                                main_d = in_data;
                            end else if (in_fire) begin
                                state_d = StTwo;
                                skid_d  = in_data;
                            end else if (out_fire) begin
                                state_d = StEmpty;
                                main_d  = '0;
                            end
                        end
                        StTwo: begin
                            if (out_fire) begin
                                state_d = StOne;
                                main_d  = skid_q;
                                skid_d  = '0;
                            end
                        end
                        default: begin
                            state_d = StEmpty;
                            main_d  = '0;
                            skid_d  = '0;
                        end
                    endcase
                end
            end
        end else begin : g_single
            logic             valid_q, valid_d;
            logic [WIDTH-1:0] main_q, main_d;
            logic             in_fire, out_fire;

            assign out_valid = valid_q;
            assign in_ready  = ~valid_q | out_ready;
            assign out_data  = main_q;
            assign occupancy = {1'b0, valid_q};
            assign in_fire   = in_valid & in_ready;
            assign out_fire  = valid_q & out_ready;

            // Entry register.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    main_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    main_q  <= main_d;
                end
            end

            // Next state; flush wins, otherwise accept replaces, drain clears to a bubble.
            always_comb begin
                valid_d = valid_q;
                main_d  = main_q;
                if (flush) begin
                    valid_d = 1'b0;
                    main_d  = '0;
                end else if (in_fire) begin
                    valid_d = 1'b1;
                    main_d  = in_data;
                end else if (out_fire) begin
                    valid_d = 1'b0;
                    main_d  = '0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_buf_stage.sv
// Directed bench for pipe_buf_stage: skid and single-entry 32-bit stages under a
// scoreboard, plus 1-bit and 300-bit stages for width pass-through.
module tb_pipe_buf_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // a: SKID=1 WIDTH=32, b: SKID=0 WIDTH=32, c: SKID=1 WIDTH=1, d: SKID=0 WIDTH=300
    logic a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0] a_occ;
    logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0] b_occ;
    logic c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [0:0] c_in_data, c_out_data;
    logic [1:0] c_occ;
    logic d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [299:0] d_in_data, d_out_data;
    logic [1:0] d_occ;

    logic [31:0] a_q[$];
    logic [31:0] b_q[$];
    int checks = 0;
    int errors = 0;

    pipe_buf_stage #(.WIDTH(32), .SKID(1'b1)) u_a (
        .clk(clk), .reset(reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );
    pipe_buf_stage #(.WIDTH(32), .SKID(1'b0)) u_b (
        .clk(clk), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
    );
    pipe_buf_stage #(.WIDTH(1), .SKID(1'b1)) u_c (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .occupancy(c_occ)
    );
    pipe_buf_stage #(.WIDTH(300), .SKID(1'b0)) u_d (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
        .occupancy(d_occ)
    );

    task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: at the falling edge score transfers that will fire on the next
    // rising edge, then return 1 time unit after that edge.
    task automatic tick();
        @(negedge clk);
        if (a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) chk("a_spurious_valid", 300'(a_out_valid), 300'(0));
            else chk("a_sb_data", 300'(a_out_data), 300'(a_q.pop_front()));
        end
        if (a_flush) a_q.delete();
        else if (a_in_valid && a_in_ready) a_q.push_back(a_in_data);
        if (b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) chk("b_spurious_valid", 300'(b_out_valid), 300'(0));
            else chk("b_sb_data", 300'(b_out_data), 300'(b_q.pop_front()));
        end
        if (b_flush) b_q.delete();
        else if (b_in_valid && b_in_ready) b_q.push_back(b_in_data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [299:0] pat;
        reset = 1'b1;
        a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
        c_in_valid = 0; c_in_data = '0; c_out_ready = 0;
        d_in_valid = 0; d_in_data = '0; d_out_ready = 0;

        // Reset state
        #2;
        chk("rst_a_out_valid", 300'(a_out_valid), 300'(0));
        chk("rst_a_out_data", 300'(a_out_data), 300'(0));
        chk("rst_a_occ", 300'(a_occ), 300'(0));
        chk("rst_a_in_ready", 300'(a_in_ready), 300'(1));
        chk("rst_b_in_ready", 300'(b_in_ready), 300'(1));
        chk("rst_b_out_valid", 300'(b_out_valid), 300'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Streaming, SKID=1
        a_out_ready = 1;
        for (int i = 1; i <= 3; i++) begin
            a_in_valid = 1; a_in_data = 32'(i);
            tick();
            chk("stream_data", 300'(a_out_data), 300'(i));
            chk("stream_occ", 300'(a_occ), 300'(1));
        end
        a_in_valid = 0;
        tick();
        chk("stream_drain_valid", 300'(a_out_valid), 300'(0));
        chk("stream_drain_occ", 300'(a_occ), 300'(0));

        // Stall fill, SKID=1
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 32'hA;
        tick();
        chk("fill1_occ", 300'(a_occ), 300'(1));
        chk("fill1_in_ready", 300'(a_in_ready), 300'(1));
        a_in_data = 32'hB;
        tick();
        chk("fill2_occ", 300'(a_occ), 300'(2));
        chk("fill2_in_ready", 300'(a_in_ready), 300'(0));
        a_in_data = 32'hC;
        tick();
        chk("fill3_occ", 300'(a_occ), 300'(2));
        chk("fill3_head", 300'(a_out_data), 300'(32'hA));
        a_out_ready = 1;
        tick();
        chk("drain_b", 300'(a_out_data), 300'(32'hB));
        chk("drain_b_in_ready", 300'(a_in_ready), 300'(1));
        tick();
        chk("drain_c", 300'(a_out_data), 300'(32'hC));
        chk("drain_c_valid", 300'(a_out_valid), 300'(1));
        a_in_valid = 0;
        tick();
        chk("drain_empty_occ", 300'(a_occ), 300'(0));

        // Flush with two held entries and an offered payload
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 32'hA;
        tick();
        a_in_data = 32'hB;
        tick();
        chk("pre_flush_occ", 300'(a_occ), 300'(2));
        a_flush = 1; a_in_data = 32'hD;
        tick();
        a_flush = 0; a_in_valid = 0;
        chk("flush_valid", 300'(a_out_valid), 300'(0));
        chk("flush_data", 300'(a_out_data), 300'(0));
        chk("flush_occ", 300'(a_occ), 300'(0));
        chk("flush_in_ready", 300'(a_in_ready), 300'(1));
        a_out_ready = 1;
        tick();
        tick();
        // Flush at one entry with concurrent in-fire and out-fire
        a_in_valid = 1; a_in_data = 32'h11;
        tick();
        a_flush = 1; a_in_data = 32'h22;
        tick();
        a_flush = 0; a_in_valid = 0;
        chk("flush1_occ", 300'(a_occ), 300'(0));
        chk("flush1_data", 300'(a_out_data), 300'(0));
        tick();

        // SKID=0 stall
        b_out_ready = 0;
        b_in_valid = 1; b_in_data = 32'h55;
        tick();
        chk("b_hold_data", 300'(b_out_data), 300'(32'h55));
        chk("b_stall_in_ready", 300'(b_in_ready), 300'(0));
        b_in_data = 32'h77;
        tick();
        chk("b_hold_data2", 300'(b_out_data), 300'(32'h55));
        chk("b_hold_occ", 300'(b_occ), 300'(1));
        b_out_ready = 1;
        b_in_data = 32'h66;
        #1;
        chk("b_comb_in_ready", 300'(b_in_ready), 300'(1));
        tick();
        chk("b_next_data", 300'(b_out_data), 300'(32'h66));
        b_in_valid = 0;
        tick();
        chk("b_empty_valid", 300'(b_out_valid), 300'(0));
        chk("b_empty_data", 300'(b_out_data), 300'(0));

        // Asynchronous reset with two held entries
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 32'h31;
        tick();
        a_in_data = 32'h32;
        tick();
        a_in_valid = 0;
        chk("pre_rst_occ", 300'(a_occ), 300'(2));
        #2;
        reset = 1'b1;
        #1;
        chk("arst_occ", 300'(a_occ), 300'(0));
        chk("arst_valid", 300'(a_out_valid), 300'(0));
        chk("arst_data", 300'(a_out_data), 300'(0));
        a_q.delete();
        b_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        a_out_ready = 1;
        a_in_valid = 1; a_in_data = 32'h41;
        tick();
        chk("post_rst_accept", 300'(a_out_data), 300'(32'h41));
        a_in_valid = 0;
        tick();

        // Width pass-through
        c_out_ready = 1; d_out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) pat = {150{2'b10}};
            else if (k % 2 == 0) pat = {300{1'b1}};
            else pat = '0;
            c_in_valid = 1; c_in_data = pat[0];
            d_in_valid = 1; d_in_data = pat;
            tick();
            chk("w1_data", 300'(c_out_data), 300'(pat[0]));
            chk("w1_valid", 300'(c_out_valid), 300'(1));
            chk("w300_data", d_out_data, pat);
        end
        c_in_valid = 0; d_in_valid = 0;
        tick();
        chk("w300_bubble", d_out_data, 300'(0));

        chk("a_drained", 300'(a_q.size()), 300'(0));
        chk("b_drained", 300'(b_q.size()), 300'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
